pixel_write_queue: RTL and testbench
====================================

# pixel_write_queue

Downstream stage of the line-drawing FSM. Accepts one pixel write request per clock: x, y, 3-bit colour and a write strobe. Requests outside the 160x120 screen are clipped. Accepted pixels are buffered in a small FIFO and drained into the framebuffer memory port with a linear address and a valid/ready handshake, so the drawing FSM never stalls on memory. Clipped and overflow drops are counted for debug.

## Interface

Parameters:
- WIDTH, 160, screen width in pixels; x valid range 0..WIDTH-1
- HEIGHT, 120, screen height in pixels; y valid range 0..HEIGHT-1
- DEPTH, 8, FIFO entries; power of two

Ports:
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- x_in  input  9  pixel x coordinate
- y_in  input  9  pixel y coordinate
- color_in  input  3  pixel colour
- wr_in  input  1  write request; sampled every rising edge
- fb_ready  input  1  framebuffer accepts the current write this cycle
- fb_addr  output  15  linear address y*WIDTH+x
- fb_data  output  3  colour for fb_addr
- fb_we  output  1  write valid; held until fb_ready
- full  output  1  FIFO holds DEPTH entries
- empty  output  1  FIFO and output register both empty
- clip_count  output  16  saturating count of out-of-range requests
- overflow_count  output  16  saturating count of in-range requests dropped while full

## Operation

- Request classification at each rising edge, only when wr_in=1:
  - in-range means x_in<WIDTH and y_in<HEIGHT
  - out-of-range: increment clip_count; nothing stored
  - in-range and !full: push {addr, color} into the FIFO
  - in-range and full: drop the request; increment overflow_count
- Full is taken from the registered occupancy only.
- No same-cycle bypass: a pop in the same cycle does not make room for a push while full=1.
- Address: fb_addr = y*WIDTH + x, computed at push time into 15 bits.
  - For WIDTH=160 this is (y<<7)+(y<<5)+x.
  - Maximum value is 19199.
- Output stage FSM, states IDLE and WRITE:
  - IDLE: fb_we=0. If the FIFO is not empty, pop the head into the output register and go to WRITE.
  - WRITE: fb_we=1; fb_addr and fb_data are held stable.
  - WRITE with fb_ready=1 and FIFO non-empty: pop the next entry in the same edge and stay in WRITE (back-to-back, one write per cycle).
  - WRITE with fb_ready=1 and FIFO empty: go to IDLE.
  - WRITE with fb_ready=0: hold everything.
- Simultaneous push and pop when not full: both take effect and occupancy is unchanged.
- Ordering is strict FIFO. Output order equals accepted input order.
- Counters saturate at 16'hFFFF and do not wrap.
- Pointers wrap modulo DEPTH. Occupancy runs 0..DEPTH and uses log2(DEPTH)+1 bits.
- Total buffering capacity is DEPTH+1 pixels (FIFO plus output register).

## Timing

- Reset (reset=0, asynchronous) sets:
  - FSM to IDLE
  - FIFO pointers and occupancy to 0
  - fb_we=0, fb_addr=0, fb_data=0
  - full=0, empty=1
  - clip_count=0, overflow_count=0
- Reset mid-operation discards all queued pixels and any held write. fb_we drops immediately, without waiting for a clock.
- Latency with an idle pipeline: request sampled at edge N → fb_we=1 with valid fb_addr/fb_data after edge N+1.
- Throughput: one pixel per clock sustained while fb_ready=1.
- full and empty are registered-state decodes and change only after an edge.
- A write is consumed at the rising edge where fb_we=1 and fb_ready=1.
- fb_ready while fb_we=0 is ignored.

## Test plan

- Single pixel (x=10, y=20, color=5), fb_ready=1:
  - fb_we=1 for exactly one cycle after edge N+1
  - fb_addr=3210, fb_data=5
  - then empty=1
- Corner pixels (0,0,c=1) then (159,119,c=7) back-to-back, fb_ready=1:
  - writes on consecutive cycles with addresses 0 then 19199
- Clipping: requests (160,0), (0,120) and (511,511) with wr_in=1:
  - no fb_we
  - clip_count=3, overflow_count=0
  - wr_in=0 with out-of-range coordinates does not change clip_count
- Backpressure: fb_ready=0, push 11 in-range pixels with colours 0..7,0..2 on successive cycles:
  - full=1 after the 9th
  - overflow_count=2
  - fb_we held with the first pixel's address unchanged
  - release fb_ready: exactly 9 writes in input order
- Simultaneous push/pop: steady stream of 20 pixels with fb_ready=1:
  - occupancy never exceeds 1
  - 20 writes in order, no drops
- Reset mid-drain: with 5 pixels queued and fb_ready=0, pulse reset low between clock edges:
  - fb_we=0 immediately
  - empty=1, counters 0
  - no further writes after release until new input arrives

Source files
------------

// File: rtl/pixel_write_queue_if.sv
// Pixel request and framebuffer write bus between the drawing FSM, the
// write queue and the framebuffer memory port.
interface pixel_write_queue_if;
   logic [8:0]  x_in;
   logic [8:0]  y_in;
   logic [2:0]  color_in;
   logic        wr_in;
   logic        fb_ready;
   logic [14:0] fb_addr;
   logic [2:0]  fb_data;
   logic        fb_we;
   logic        full;
   logic        empty;
   logic [15:0] clip_count;
   logic [15:0] overflow_count;

   // Environment side: issues pixel requests and acts as the framebuffer.
   modport master (
      output x_in, y_in, color_in, wr_in, fb_ready,
      input  fb_addr, fb_data, fb_we, full, empty, clip_count, overflow_count
   );

   // Queue side.
   modport slave (
      input  x_in, y_in, color_in, wr_in, fb_ready,
      output fb_addr, fb_data, fb_we, full, empty, clip_count, overflow_count
   );
endinterface

// File: rtl/pixel_write_queue.sv
// Clips pixel write requests to the screen, buffers accepted pixels in a
// small FIFO and drains them to the framebuffer through a valid/ready port
// so the drawing FSM never stalls on memory.
module pixel_write_queue #(
   parameter int WIDTH  = 160,
   parameter int HEIGHT = 120,
   parameter int DEPTH  = 8
) (
   input  logic                clk,
   input  logic                reset,
   pixel_write_queue_if.slave  bus
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic {IDLE, WRITE} state_t;

   typedef struct packed {
      logic [14:0] addr;
      logic [2:0]  color;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   state_t        state;
   state_t        state_next;
   entry_t        out_q;
   logic [15:0]   clip_q;
   logic [15:0]   overflow_q;

   logic          in_range;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic [14:0]   addr_w;

   assign in_range   = (bus.x_in < 9'(WIDTH)) && (bus.y_in < 9'(HEIGHT));
   assign fifo_full  = (count == (PW+1)'(DEPTH));
   assign fifo_empty = (count == '0);
   assign addr_w     = 15'(bus.y_in) * 15'(WIDTH) + 15'(bus.x_in);

   // Full blocks a push even if the output stage pops on the same edge.
   assign push = bus.wr_in && in_range && !fifo_full;
   // Load the output register when it is free or being consumed this edge.
   assign pop  = !fifo_empty && ((state == IDLE) || bus.fb_ready);

   // Pixel storage; only the slots between the pointers are meaningful.
   // NOTE: the array has no reset -- the pointers and occupancy define which
   // slots are valid, so clearing the contents would only cost logic.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{addr: addr_w, color: bus.color_in};
   end

   // FIFO pointers and occupancy.
   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Output register holding the pixel currently offered to the framebuffer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)   out_q <= '0;
      else if (pop) out_q <= mem[rd_ptr];
   end

   // Output stage state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Output stage next-state logic.
   // NOTE: state_next gets a default before the case so no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (!fifo_empty) state_next = WRITE;
         WRITE:   if (bus.fb_ready && fifo_empty) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output stage outputs; fb_we follows the state so reset drops it at once.
   always_comb begin
      bus.fb_we = (state == WRITE);
   end

   // Saturating debug counters for clipped and overflow-dropped requests.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clip_q     <= '0;
         overflow_q <= '0;
      end else if (bus.wr_in) begin
         if (!in_range && clip_q != 16'hFFFF)
            clip_q <= clip_q + 16'd1;
         if (in_range && fifo_full && overflow_q != 16'hFFFF)
            overflow_q <= overflow_q + 16'd1;
      end
   end

   assign bus.fb_addr        = out_q.addr;
   assign bus.fb_data        = out_q.color;
   assign bus.full           = fifo_full;
   assign bus.empty          = fifo_empty && (state == IDLE);
   assign bus.clip_count     = clip_q;
   assign bus.overflow_count = overflow_q;

endmodule

// File: tb/tb_pixel_write_queue.sv
// Self-checking bench for pixel_write_queue: a table of directed vectors,
// hand-written corner sequences and a randomized run, all compared against a
// queue-based reference model of the clip / buffer / drain behaviour.
module tb_pixel_write_queue;

   localparam int WIDTH  = 160;
   localparam int HEIGHT = 120;
   localparam int DEPTH  = 8;

   logic clk = 1'b0;
   logic reset;

   pixel_write_queue_if bus ();

   pixel_write_queue #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int writes_seen = 0;

   // Reference model: a queue of buffered pixels plus one held output slot.
   typedef struct {
      int addr;
      int color;
   } pix_t;

   pix_t m_fifo[$];
   bit   m_out_v;
   pix_t m_out;
   int   m_clip;
   int   m_ovf;

   typedef struct {
      int x, y, c;
      bit wr, rdy;
      bit we;
      int addr, data;
      bit emp;
      int clip, ovf;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_fifo.delete();
      m_out_v = 1'b0;
      m_out   = '{0, 0};
      m_clip  = 0;
      m_ovf   = 0;
   endtask

   task automatic model_edge(input int x, y, c, input bit wr, rdy);
      bit full_pre = (m_fifo.size() == DEPTH);
      bit have_pre = (m_fifo.size() != 0);
      bit accept   = 1'b0;
      if (wr) begin
         if (!(x < WIDTH && y < HEIGHT)) begin
            if (m_clip < 65535) m_clip++;
         end else if (full_pre) begin
            if (m_ovf < 65535) m_ovf++;
         end else begin
            accept = 1'b1;
         end
      end
      if (m_out_v && rdy) m_out_v = 1'b0;
      if (!m_out_v && have_pre) begin
         m_out   = m_fifo.pop_front();
         m_out_v = 1'b1;
      end
      if (accept) m_fifo.push_back('{y * WIDTH + x, c});
   endtask

   task automatic model_check();
      check("we", 32'(bus.fb_we), 32'(m_out_v));
      if (m_out_v) begin
         check("addr", 32'(bus.fb_addr), 32'(m_out.addr));
         check("data", 32'(bus.fb_data), 32'(m_out.color));
      end
      check("full",  32'(bus.full),  32'(m_fifo.size() == DEPTH));
      check("empty", 32'(bus.empty), 32'(m_fifo.size() == 0 && !m_out_v));
      check("clip",  32'(bus.clip_count),     32'(m_clip));
      check("ovf",   32'(bus.overflow_count), 32'(m_ovf));
   endtask

   // One clock: drive at the falling edge, let the rising edge act, compare
   // at the next falling edge.
   task automatic step(input int x, y, c, input bit wr, rdy);
      bus.x_in     = 9'(x);
      bus.y_in     = 9'(y);
      bus.color_in = 3'(c);
      bus.wr_in    = wr;
      bus.fb_ready = rdy;
      if (bus.fb_we && rdy) writes_seen++;
      @(posedge clk);
      model_edge(x, y, c, wr, rdy);
      @(negedge clk);
      model_check();
   endtask

   task automatic apply_reset();
      bus.wr_in    = 1'b0;
      bus.fb_ready = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   initial begin
      reset        = 1'b0;
      bus.x_in     = '0;
      bus.y_in     = '0;
      bus.color_in = '0;
      bus.wr_in    = 1'b0;
      bus.fb_ready = 1'b0;
      model_reset();

      // Reset state.
      #12;
      check("rst_we",    32'(bus.fb_we), 0);
      check("rst_addr",  32'(bus.fb_addr), 0);
      check("rst_data",  32'(bus.fb_data), 0);
      check("rst_full",  32'(bus.full), 0);
      check("rst_empty", 32'(bus.empty), 1);
      check("rst_clip",  32'(bus.clip_count), 0);
      check("rst_ovf",   32'(bus.overflow_count), 0);
      @(negedge clk);
      reset = 1'b1;

      // Directed vectors: single pixel, corner pixels, clipping.
      //            x    y    c  wr rdy  we  addr   data emp clip ovf
      vecs[0]  = '{ 10,  20, 5, 1, 1,  0,     0, 0,  0,  0,  0};
      vecs[1]  = '{  0,   0, 0, 0, 1,  1,  3210, 5,  0,  0,  0};
      vecs[2]  = '{  0,   0, 0, 0, 1,  0,     0, 0,  1,  0,  0};
      vecs[3]  = '{  0,   0, 1, 1, 1,  0,     0, 0,  0,  0,  0};
      vecs[4]  = '{159, 119, 7, 1, 1,  1,     0, 1,  0,  0,  0};
      vecs[5]  = '{  0,   0, 0, 0, 1,  1, 19199, 7,  0,  0,  0};
      vecs[6]  = '{  0,   0, 0, 0, 1,  0,     0, 0,  1,  0,  0};
      vecs[7]  = '{160,   0, 3, 1, 1,  0,     0, 0,  1,  1,  0};
      vecs[8]  = '{  0, 120, 3, 1, 1,  0,     0, 0,  1,  2,  0};
      vecs[9]  = '{511, 511, 3, 1, 1,  0,     0, 0,  1,  3,  0};
      vecs[10] = '{511, 511, 3, 0, 1,  0,     0, 0,  1,  3,  0};
      for (int i = 0; i < 11; i++) begin
         step(vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].wr, vecs[i].rdy);
         check($sformatf("vec%0d_we", i), 32'(bus.fb_we), 32'(vecs[i].we));
         if (vecs[i].we) begin
            check($sformatf("vec%0d_addr", i), 32'(bus.fb_addr), 32'(vecs[i].addr));
            check($sformatf("vec%0d_data", i), 32'(bus.fb_data), 32'(vecs[i].data));
         end
         check($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'(vecs[i].emp));
         check($sformatf("vec%0d_clip", i), 32'(bus.clip_count), 32'(vecs[i].clip));
         check($sformatf("vec%0d_ovf", i), 32'(bus.overflow_count), 32'(vecs[i].ovf));
      end

      // Backpressure: 11 pushes into a stalled port, 9 fit.
      apply_reset();
      for (int i = 0; i < 11; i++) begin
         step(i * 3, i + 1, i % 8, 1'b1, 1'b0);
         if (i == 7) check("bp_not_full8", 32'(bus.full), 0);
         if (i == 8) check("bp_full9", 32'(bus.full), 1);
      end
      check("bp_ovf", 32'(bus.overflow_count), 2);
      check("bp_we_held", 32'(bus.fb_we), 1);
      check("bp_addr_held", 32'(bus.fb_addr), 160);
      step(0, 0, 0, 1'b0, 1'b0);
      check("bp_addr_still", 32'(bus.fb_addr), 160);
      writes_seen = 0;
      for (int i = 0; i < 14; i++) step(0, 0, 0, 1'b0, 1'b1);
      check("bp_writes", 32'(writes_seen), 9);
      check("bp_drained", 32'(bus.empty), 1);

      // Steady stream with simultaneous push and pop.
      apply_reset();
      writes_seen = 0;
      for (int i = 0; i < 20; i++) begin
         step(i * 7, i * 5, i % 8, 1'b1, 1'b1);
         check("st_not_full", 32'(bus.full), 0);
      end
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1'b0, 1'b1);
      check("st_writes", 32'(writes_seen), 20);
      check("st_ovf", 32'(bus.overflow_count), 0);

      // Randomized traffic with random backpressure.
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         step(int'($urandom_range(0, 200)), int'($urandom_range(0, 150)),
              int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 2) != 0));
      end
      for (int i = 0; i < 12; i++) step(0, 0, 0, 1'b0, 1'b1);
      check("rnd_drained", 32'(bus.empty), 1);

      // Reset mid-drain: asynchronous, fb_we drops before any clock.
      apply_reset();
      step(511, 0, 0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(i + 1, i + 2, i, 1'b1, 1'b0);
      check("md_we_before", 32'(bus.fb_we), 1);
      #2;
      reset = 1'b0;
      #1;
      check("md_we_now",  32'(bus.fb_we), 0);
      check("md_empty",   32'(bus.empty), 1);
      check("md_full",    32'(bus.full), 0);
      check("md_clip",    32'(bus.clip_count), 0);
      check("md_ovf",     32'(bus.overflow_count), 0);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      writes_seen = 0;
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1'b0, 1'b1);
      check("md_no_writes", 32'(writes_seen), 0);
      step(3, 4, 6, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1'b0, 1'b1);
      check("md_new_write", 32'(writes_seen), 1);

      // Clip counter saturation.
      apply_reset();
      bus.x_in  = 9'd511;
      bus.y_in  = 9'd0;
      bus.wr_in = 1'b1;
      repeat (65540) @(posedge clk);
      @(negedge clk);
      bus.wr_in = 1'b0;
      check("sat_clip", 32'(bus.clip_count), 32'hFFFF);
      check("sat_ovf",  32'(bus.overflow_count), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
